// File: rtl/cpu_defs.sv
// Shared RV32I decode definitions: opcodes, ALU/writeback codes, ID/EX bundle.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cpu_defs;

  localparam int XLEN = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    ctrl_t           ctrl;
  } idex_t;

  // A bubble has every control flag cleared and alu_op = ADD; the data
  // fields are zeroed too so an idle stage is easy to spot on waveforms.
  localparam ctrl_t CTRL_BUBBLE = '0;
  localparam idex_t IDEX_BUBBLE = '0;

  // funct3/funct7[5] to ALU op for OP (is_reg = 1) and OP-IMM (is_reg = 0).
  // funct7[5] selects SUB only for register ops: for ADDI that bit is
  // part of the immediate.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry integer register file, two async read ports, one sync write port.
// Latency: reads combinational; writes visible after the next posedge clk.
// Backpressure: none; a write is accepted every cycle wb is enabled.
//
// Ports: clk, rst_n (async active-low, clears all registers);
//        rs1_addr/rs2_addr -> rs1_data/rs2_data; we, rd_addr, rd_data.
// Build option ID_WB_BYPASS_EN: a read of the register being written this
// cycle returns the incoming write data instead of the stored value.
module regfile
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [DATA_WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (rd_addr != '0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef ID_WB_BYPASS_EN
    if (we && (rd_addr != '0) && (rd_addr == rs1_addr)) rs1_data = rd_data;
    if (we && (rd_addr != '0) && (rd_addr == rs2_addr)) rs2_data = rd_data;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediate gen, regfile read, load-use detect.
// Latency: 1 cycle IF_instr_i -> ID_* (ID/EX register); hazard_stall_o same cycle.
// Backpressure: stall holds ID/EX; load-use inserts a bubble; flush wins over both.
//
// Ports: IF_pc_i/IF_instr_i from fetch; flush, stall; ex_mem_read_i/ex_rd_i
//        from EX for hazard detection; wb_we_i/wb_rd_i/wb_data_i writeback;
//        hazard_stall_o to fetch; ID_* registered bundle to execute.
// Build option ID_WB_BYPASS_EN: same-cycle writeback-to-read bypass in regfile.
module id_stage
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] IF_pc_i,
  input  logic [31:0]           IF_instr_i,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  hazard_stall_o,
  output logic [DATA_WIDTH-1:0] ID_pc_o,
  output logic [DATA_WIDTH-1:0] ID_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ID_rs2_data_o,
  output logic [DATA_WIDTH-1:0] ID_imm_o,
  output logic [REG_ADDR_W-1:0] ID_rs1_o,
  output logic [REG_ADDR_W-1:0] ID_rs2_o,
  output logic [REG_ADDR_W-1:0] ID_rd_o,
  output logic [2:0]            ID_funct3_o,
  output logic [3:0]            ID_alu_op_o,
  output logic                  ID_alu_src_a_o,
  output logic                  ID_alu_src_b_o,
  output logic [1:0]            ID_wb_sel_o,
  output logic                  ID_reg_write_o,
  output logic                  ID_mem_read_o,
  output logic                  ID_mem_write_o,
  output logic                  ID_branch_o,
  output logic                  ID_jump_o,
  output logic                  ID_jalr_o,
  output logic                  ID_illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [4:0]  rd_idx, rs2_idx;
  logic [4:0]  rs1_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = IF_instr_i[6:0];
  assign rd_idx  = IF_instr_i[11:7];
  assign funct3  = IF_instr_i[14:12];
  assign rs2_idx = IF_instr_i[24:20];
  assign f7b5    = IF_instr_i[30];

  assign imm_i = {{20{IF_instr_i[31]}}, IF_instr_i[31:20]};
  assign imm_s = {{20{IF_instr_i[31]}}, IF_instr_i[31:25], IF_instr_i[11:7]};
  assign imm_b = {{19{IF_instr_i[31]}}, IF_instr_i[31], IF_instr_i[7],
                  IF_instr_i[30:25], IF_instr_i[11:8], 1'b0};
  assign imm_u = {IF_instr_i[31:12], 12'b0};
  assign imm_j = {{11{IF_instr_i[31]}}, IF_instr_i[31], IF_instr_i[19:12],
                  IF_instr_i[20], IF_instr_i[30:21], 1'b0};

  ctrl_t       ctrl;
  logic [31:0] imm;
  logic        rs1_used, rs2_used;

  always_comb begin
    ctrl     = CTRL_BUBBLE;
    imm      = '0;
    rs1_idx  = IF_instr_i[19:15];
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_LUI: begin
        // Index forced to x0 so EX computes 0 + imm with the plain ADD path.
        rs1_idx        = '0;
        imm            = imm_u;
        ctrl.alu_src_b = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm            = imm_u;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        // ALU forms the target PC + imm; rd gets PC+4 through wb_sel.
        imm            = imm_j;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OPC_JALR: begin
        imm            = imm_i;
        ctrl.alu_src_b = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.reg_write = 1'b1;
        ctrl.jalr      = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_BRANCH: begin
        imm            = imm_b;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_LOAD: begin
        imm            = imm_i;
        ctrl.alu_src_b = 1'b1;
        ctrl.wb_sel    = WB_MEM;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_STORE: begin
        imm            = imm_s;
        ctrl.alu_src_b = 1'b1;
        ctrl.mem_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_OPIMM: begin
        imm            = imm_i;
        ctrl.alu_op    = alu_decode(funct3, f7b5, 1'b0);
        ctrl.alu_src_b = 1'b1;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_OP: begin
        ctrl.alu_op    = alu_decode(funct3, f7b5, 1'b1);
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      default: begin
        // The all-zero word is fetch's flush marker, not an illegal op.
        ctrl.illegal = (IF_instr_i != '0);
      end
    endcase
  end

  logic [DATA_WIDTH-1:0] rs1_rdata, rs2_rdata;

  regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_idx),
    .rs2_addr (rs2_idx),
    .rs1_data (rs1_rdata),
    .rs2_data (rs2_rdata),
    .we       (wb_we_i),
    .rd_addr  (wb_rd_i),
    .rd_data  (wb_data_i)
  );

  assign hazard_stall_o = ex_mem_read_i && (ex_rd_i != '0) &&
                          (((ex_rd_i == rs1_idx) && rs1_used) ||
                           ((ex_rd_i == rs2_idx) && rs2_used));

  idex_t dec, idex_q;

  always_comb begin
    dec          = IDEX_BUBBLE;
    dec.pc       = IF_pc_i;
    dec.rs1_data = rs1_rdata;
    dec.rs2_data = rs2_rdata;
    dec.imm      = imm;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = rd_idx;
    dec.funct3   = funct3;
    dec.ctrl     = ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= IDEX_BUBBLE;
    end else if (flush) begin
      idex_q <= IDEX_BUBBLE;
    end else if (!stall) begin
      idex_q <= hazard_stall_o ? IDEX_BUBBLE : dec;
    end
  end

  assign ID_pc_o        = idex_q.pc;
  assign ID_rs1_data_o  = idex_q.rs1_data;
  assign ID_rs2_data_o  = idex_q.rs2_data;
  assign ID_imm_o       = idex_q.imm;
  assign ID_rs1_o       = idex_q.rs1;
  assign ID_rs2_o       = idex_q.rs2;
  assign ID_rd_o        = idex_q.rd;
  assign ID_funct3_o    = idex_q.funct3;
  assign ID_alu_op_o    = idex_q.ctrl.alu_op;
  assign ID_alu_src_a_o = idex_q.ctrl.alu_src_a;
  assign ID_alu_src_b_o = idex_q.ctrl.alu_src_b;
  assign ID_wb_sel_o    = idex_q.ctrl.wb_sel;
  assign ID_reg_write_o = idex_q.ctrl.reg_write;
  assign ID_mem_read_o  = idex_q.ctrl.mem_read;
  assign ID_mem_write_o = idex_q.ctrl.mem_write;
  assign ID_branch_o    = idex_q.ctrl.branch;
  assign ID_jump_o      = idex_q.ctrl.jump;
  assign ID_jalr_o      = idex_q.ctrl.jalr;
  assign ID_illegal_o   = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: hand-decoded expectations queued per driven instruction.
// Latency: each queued record is compared one clock after it is driven.
// Backpressure: stall/flush/hazard cases queue the held or bubble record.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IF_pc_i = '0;
  logic [31:0] IF_instr_i = '0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        ex_mem_read_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;

  logic        hazard_stall_o;
  logic [31:0] ID_pc_o, ID_rs1_data_o, ID_rs2_data_o, ID_imm_o;
  logic [4:0]  ID_rs1_o, ID_rs2_o, ID_rd_o;
  logic [2:0]  ID_funct3_o;
  logic [3:0]  ID_alu_op_o;
  logic        ID_alu_src_a_o, ID_alu_src_b_o;
  logic [1:0]  ID_wb_sel_o;
  logic        ID_reg_write_o, ID_mem_read_o, ID_mem_write_o;
  logic        ID_branch_o, ID_jump_o, ID_jalr_o, ID_illegal_o;

  id_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_pc_i        (IF_pc_i),
    .IF_instr_i     (IF_instr_i),
    .flush          (flush),
    .stall          (stall),
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_rd_i        (ex_rd_i),
    .wb_we_i        (wb_we_i),
    .wb_rd_i        (wb_rd_i),
    .wb_data_i      (wb_data_i),
    .hazard_stall_o (hazard_stall_o),
    .ID_pc_o        (ID_pc_o),
    .ID_rs1_data_o  (ID_rs1_data_o),
    .ID_rs2_data_o  (ID_rs2_data_o),
    .ID_imm_o       (ID_imm_o),
    .ID_rs1_o       (ID_rs1_o),
    .ID_rs2_o       (ID_rs2_o),
    .ID_rd_o        (ID_rd_o),
    .ID_funct3_o    (ID_funct3_o),
    .ID_alu_op_o    (ID_alu_op_o),
    .ID_alu_src_a_o (ID_alu_src_a_o),
    .ID_alu_src_b_o (ID_alu_src_b_o),
    .ID_wb_sel_o    (ID_wb_sel_o),
    .ID_reg_write_o (ID_reg_write_o),
    .ID_mem_read_o  (ID_mem_read_o),
    .ID_mem_write_o (ID_mem_write_o),
    .ID_branch_o    (ID_branch_o),
    .ID_jump_o      (ID_jump_o),
    .ID_jalr_o      (ID_jalr_o),
    .ID_illegal_o   (ID_illegal_o)
  );

  always #5 clk = ~clk;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

  // Flag vector order: {src_a, src_b, wb_sel[1:0], reg_write, mem_read,
  //                     mem_write, branch, jump, jalr, illegal}
  logic [10:0] dut_flags;
  assign dut_flags = {ID_alu_src_a_o, ID_alu_src_b_o, ID_wb_sel_o, ID_reg_write_o,
                      ID_mem_read_o, ID_mem_write_o, ID_branch_o, ID_jump_o,
                      ID_jalr_o, ID_illegal_o};

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [10:0] flags;
    logic [10:0] mask;
    logic        chk_alu;
    logic        chk_data;
    logic        haz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] flg(input logic a, input logic b, input logic [1:0] wb,
                                      input logic rw, input logic mr, input logic mw,
                                      input logic br, input logic j, input logic jr,
                                      input logic ill);
    return {a, b, wb, rw, mr, mw, br, j, jr, ill};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [3:0] alu,
                              input logic [10:0] flags, input logic [31:0] rs1d);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.alu = alu; e.flags = flags; e.rs1d = rs1d;
    e.mask = '1; e.chk_alu = 1'b1; e.chk_data = 1'b1; e.haz = 1'b0;
    return e;
  endfunction

  function automatic exp_t bubble(input logic haz);
    exp_t e;
    e = mk('0, '0, '0, 4'd0, '0, '0);
    e.chk_data = 1'b0;
    e.haz = haz;
    return e;
  endfunction

  // Called just after a posedge: drive, check the combinational hazard
  // output, clock once, then compare the ID/EX record that should result.
  task automatic run(input string tag, input logic [31:0] instr,
                     input logic [31:0] pc, input exp_t e);
    exp_t x;
    IF_instr_i = instr;
    IF_pc_i    = pc;
    sb.push_back(e);
    #1;
    check_eq({tag, ".haz"}, {31'd0, hazard_stall_o}, {31'd0, e.haz});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_eq({tag, ".flags"}, {21'd0, dut_flags & x.mask}, {21'd0, x.flags & x.mask});
    if (x.chk_alu) check_eq({tag, ".alu"}, {28'd0, ID_alu_op_o}, {28'd0, x.alu});
    if (x.chk_data) begin
      check_eq({tag, ".pc"},  ID_pc_o, x.pc);
      check_eq({tag, ".imm"}, ID_imm_o, x.imm);
      check_eq({tag, ".rd"},  {27'd0, ID_rd_o}, {27'd0, x.rd});
      check_eq({tag, ".rs1d"}, ID_rs1_data_o, x.rs1d);
    end
  endtask

  exp_t e;
  logic [10:0] F_IMM, F_REG;

  initial begin
    F_IMM = flg(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    F_REG = flg(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    check_eq("rst.pc",    ID_pc_o, 32'h0);
    check_eq("rst.imm",   ID_imm_o, 32'h0);
    check_eq("rst.data",  ID_rs1_data_o | ID_rs2_data_o, 32'h0);
    check_eq("rst.idx",   {14'd0, ID_rd_o, ID_rs1_o, ID_rs2_o, ID_funct3_o}, 32'h0);
    check_eq("rst.ctrl",  {17'd0, ID_alu_op_o, dut_flags}, 32'h0);
    check_eq("rst.haz",   {31'd0, hazard_stall_o}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode coverage; x1 <= 0x11 written alongside the first instruction
    wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h11;
    run("addi", 32'h00500093, 32'h000, mk(32'h000, 32'd5, 5'd1, 4'd0, F_IMM, 32'h0));
    wb_we_i = 1'b0;
    run("beq", 32'hFE000EE3, 32'h004,
        mk(32'h004, 32'hFFFFFFFC, 5'd29, 4'd1,
           flg(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 32'h0));
    run("lui", 32'h123452B7, 32'h008, mk(32'h008, 32'h12345000, 5'd5, 4'd0, F_IMM, 32'h0));
    check_eq("lui.rs1idx", {27'd0, ID_rs1_o}, 32'h0);
    run("auipc", 32'h00001317, 32'h100,
        mk(32'h100, 32'h1000, 5'd6, 4'd0,
           flg(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 32'h0));
    e = mk(32'h104, 32'd8, 5'd1, 4'd0,
           flg(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 32'h0);
    e.mask = 11'b001_1111_1111; e.chk_alu = 1'b0;
    run("jal", 32'h008000EF, 32'h104, e);
    e = mk(32'h108, 32'd4, 5'd0, 4'd0,
           flg(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 32'h11);
    e.mask = 11'b111_1111_1011; e.chk_alu = 1'b0;
    run("jalr", 32'h00408067, 32'h108, e);
    run("lw", 32'hFF812383, 32'h10C,
        mk(32'h10C, 32'hFFFFFFF8, 5'd7, 4'd0,
           flg(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 32'h0));
    run("sw", 32'h00312623, 32'h110,
        mk(32'h110, 32'd12, 5'd12, 4'd0,
           flg(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 32'h0));
    run("sub",  32'h40208233, 32'h114, mk(32'h114, 32'h0, 5'd4, 4'd1, F_REG, 32'h11));
    run("srai", 32'h4030D293, 32'h118, mk(32'h118, 32'h403, 5'd5, 4'd7, F_IMM, 32'h11));
    run("and",  32'h0020F433, 32'h11C, mk(32'h11C, 32'h0, 5'd8, 4'd9, F_REG, 32'h11));
    e = bubble(1'b0);
    e.flags = flg(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run("illegal", 32'hFFFFFFFF, 32'h120, e);
    run("zero", 32'h00000000, 32'h124, bubble(1'b0));

    // Load-use hazards
    ex_mem_read_i = 1'b1; ex_rd_i = 5'd1;
    run("hz.add", 32'h00108133, 32'h200, bubble(1'b1));
    ex_rd_i = 5'd8;   // matches LUI's rs1 field, which LUI does not read
    run("hz.lui", 32'h123452B7, 32'h204, mk(32'h204, 32'h12345000, 5'd5, 4'd0, F_IMM, 32'h0));
    ex_rd_i = 5'd5;   // matches ADDI's rs2 field, which ADDI does not read
    run("hz.addi", 32'h00500093, 32'h208, mk(32'h208, 32'd5, 5'd1, 4'd0, F_IMM, 32'h0));
    ex_rd_i = 5'd0;
    run("hz.rd0", 32'h00108133, 32'h200, mk(32'h200, 32'h0, 5'd2, 4'd0, F_REG, 32'h11));
    ex_mem_read_i = 1'b0;

    // Writeback into a register read in the same cycle
    wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEADBEEF;
    run("wb.same", 32'h00018513, 32'h300, mk(32'h300, 32'h0, 5'd10, 4'd0, F_IMM, BYP_EXP));
    wb_we_i = 1'b0;
    run("wb.after", 32'h00018513, 32'h304, mk(32'h304, 32'h0, 5'd10, 4'd0, F_IMM, 32'hDEADBEEF));
    wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h55;
    run("x0.same", 32'h00000593, 32'h308, mk(32'h308, 32'h0, 5'd11, 4'd0, F_IMM, 32'h0));
    wb_we_i = 1'b0;
    run("x0.after", 32'h00000593, 32'h30C, mk(32'h30C, 32'h0, 5'd11, 4'd0, F_IMM, 32'h0));

    // Flush priority
    flush = 1'b1; stall = 1'b1;
    run("flush+stall", 32'h00500093, 32'h400, bubble(1'b0));
    stall = 1'b0; ex_mem_read_i = 1'b1; ex_rd_i = 5'd1;
    run("flush+haz", 32'h00108133, 32'h404, bubble(1'b1));
    flush = 1'b0; ex_mem_read_i = 1'b0; ex_rd_i = 5'd0;

    // Stall holds the last bundle while fetch presents something else
    run("pre.stall", 32'h00500093, 32'h500, mk(32'h500, 32'd5, 5'd1, 4'd0, F_IMM, 32'h0));
    stall = 1'b1;
    for (int i = 0; i < 3; i++)
      run("stall", 32'hFE000EE3, 32'h504, mk(32'h500, 32'd5, 5'd1, 4'd0, F_IMM, 32'h0));
    stall = 1'b0;

    // Asynchronous reset in the middle of a cycle
    run("pre.rst", 32'h00500093, 32'h600, mk(32'h600, 32'd5, 5'd1, 4'd0, F_IMM, 32'h0));
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst.pc",   ID_pc_o, 32'h0);
    check_eq("midrst.imm",  ID_imm_o, 32'h0);
    check_eq("midrst.ctrl", {17'd0, ID_alu_op_o, dut_flags}, 32'h0);
    check_eq("midrst.rd",   {27'd0, ID_rd_o}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run("x1.cleared", 32'h00008613, 32'h700, mk(32'h700, 32'h0, 5'd12, 4'd0, F_IMM, 32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch. It holds the 32-entry register file. Each cycle it decodes the fetched instruction and PC, generates the immediate, reads both source registers, and detects load-use hazards. The decoded bundle is registered into the ID/EX pipeline register, which feeds the execute stage.

## Interface
- DATA_WIDTH, 32, datapath and register width
- REG_ADDR_W, 5, register index width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- IF_pc_i  in  32  PC of the instruction in decode
- IF_instr_i  in  32  instruction word (0 = flushed by fetch)
- flush  in  1  squash ID/EX contents (taken branch/jump)
- stall  in  1  external freeze; hold ID/EX
- ex_mem_read_i  in  1  instruction now in EX is a load
- ex_rd_i  in  5  destination of the instruction in EX
- wb_we_i  in  1  writeback enable
- wb_rd_i  in  5  writeback index
- wb_data_i  in  32  writeback data
- hazard_stall_o  out  1  load-use stall request to fetch (combinational)
- ID_pc_o  out  32  registered PC
- ID_rs1_data_o, ID_rs2_data_o  out  32  registered operands
- ID_imm_o  out  32  registered sign-extended immediate
- ID_rs1_o, ID_rs2_o, ID_rd_o  out  5  registered indices
- ID_funct3_o  out  3  registered funct3
- ID_alu_op_o  out  4  ALU operation
- ID_alu_src_a_o  out  1  0 = rs1, 1 = PC
- ID_alu_src_b_o  out  1  0 = rs2, 1 = imm
- ID_wb_sel_o  out  2  0 = ALU, 1 = memory, 2 = PC+4
- ID_reg_write_o, ID_mem_read_o, ID_mem_write_o, ID_branch_o, ID_jump_o, ID_jalr_o, ID_illegal_o  out  1  control flags

## Operation
- Decode covers the opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
- LUI forces the rs1 index to 0 and uses ADD, so the result is 0 + imm.
- AUIPC sets src_a = PC and uses ADD.
- JAL and JALR set wb_sel = 2.
- ALU op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - SUB is used when OP has funct7[5] = 1.
  - SRA is used when funct7[5] = 1 for shifts (OP or OP-IMM).
  - BRANCH uses SUB.
- Immediate formats: I, S, B, U and J, each sign-extended from bit 31. R-type gives imm = 0.
- An unknown opcode sets ID_illegal_o = 1 with all other control flags 0. The all-zero word decodes as a bubble with illegal = 0.
- Register file: 32×32 bits.
  - x0 always reads 0; writes to x0 are ignored.
  - Reads are asynchronous; writes happen on posedge clk.
- Load-use hazard: hazard_stall_o = ex_mem_read_i & (ex_rd_i != 0) & ((ex_rd_i == rs1 & rs1 used) | (ex_rd_i == rs2 & rs2 used)).
  - rs1 is "used" by all opcodes except LUI, AUIPC and JAL.
  - rs2 is "used" only by OP, STORE and BRANCH.
- ID/EX update priority, evaluated at each posedge:
  1. flush: load a bubble.
  2. else stall: hold all outputs.
  3. else hazard_stall_o: load a bubble.
  4. else: load the decoded bundle.
- A bubble means every control flag is 0 and alu_op = 0. PC, data and indices may take any value.

## Timing
- Decode and register read are combinational; results appear on the ID_* outputs one cycle after IF_instr_i is presented.
- hazard_stall_o is a same-cycle combinational output. Fetch holds the PC and instruction for exactly one cycle per hazard.
- Reset (asynchronous assert, synchronous release):
  - all ID_* outputs are 0;
  - all registers are 0;
  - hazard_stall_o is driven purely by inputs.
- When reset is asserted mid-operation, the pipeline register and register file clear immediately. No write completes in that cycle.
- When a writeback and a read of the same register (nonzero index) happen in the same cycle, the behaviour is set by the macro below.
- When flush and hazard occur in the same cycle, flush wins. hazard_stall_o is still asserted, and fetch gives flush precedence.

## Configuration
- ID_WB_BYPASS_EN
  - Defined: a read of wb_rd_i while wb_we_i = 1 (and wb_rd_i != 0) returns wb_data_i in the same cycle.
  - Undefined: the read returns the old register value. Forwarding logic downstream must cover the WB→ID distance.

## Structure
- Shared package/header cpu_defs holds:
  - opcode localparams;
  - ALU op codes;
  - wb_sel codes;
  - bubble constant.
- One sub-module, regfile: two asynchronous read ports, one synchronous write port, async reset, and the bypass governed by ID_WB_BYPASS_EN.
- Decoder, immediate generator and hazard logic live in id_stage.

## Test plan
- addi x1,x0,5 (0x00500093) → next cycle:
  - imm = 5, rd = 1, alu_op = 0, src_b = 1, reg_write = 1.
- beq x0,x0,-4 (0xFE000EE3) → imm = 0xFFFFFFFC, branch = 1, alu_op = 1, reg_write = 0.
- ex_mem_read_i = 1, ex_rd_i = 1, instr add x2,x1,x1 (0x00108133):
  - hazard_stall_o = 1 the same cycle;
  - the next ID/EX is a bubble;
  - with ex_rd_i = 0 there is no stall.
- wb_we_i = 1, wb_rd_i = 3, wb_data_i = 0xDEADBEEF while decoding a read of x3:
  - with the macro defined, rs1_data = 0xDEADBEEF;
  - without it, rs1_data = 0 (the old value);
  - a write to x0 never changes reads of x0.
- flush and stall asserted together → bubble. stall alone → outputs held unchanged for 3 cycles.
- Assert rst_n low asynchronously mid-stream → all ID_* outputs go to 0 immediately, and x1 reads 0 after release.
